// File: rtl/hdmi_ctrl_pkg.sv
// Shared definitions for the HDMI source-switch sequencer: state encoding and
// default timing constants reused by the PLL wrapper and the bench.
package hdmi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_MUTE,
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_WAIT_VS,
        ST_FAIL
    } ctrl_state_t;

    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_RST_CYC      = 16;
    localparam int unsigned DEF_LOCK_STABLE  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT = 1048576;
    localparam int unsigned DEF_MAX_RETRY    = 3;
    localparam int unsigned DEF_VS_SETTLE    = 2;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hdmi_sync_bit.sv
// Multi-flop synchroniser for one asynchronous control bit.
module hdmi_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sr <= '0;
        else
            sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/hdmi_src_switch_ctrl.sv
// Sequencer for switching the HDMI source between VGA and FT812: mute, reset
// the HDMI PLL, wait for stable lock and frame sync, then unmute.
module hdmi_src_switch_ctrl
    import hdmi_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned RST_CYC      = DEF_RST_CYC,
    parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY,
    parameter int unsigned VS_SETTLE    = DEF_VS_SETTLE
) (
    input  logic clk,
    input  logic reset,
    input  logic sel_req,
    input  logic pll_locked,
    input  logic vs_in,
    output logic sel_out,
    output logic pll_rst,
    output logic mute,
    output logic busy,
    output logic fail
);

    localparam int unsigned RC_W = cnt_w(RST_CYC);
    localparam int unsigned SB_W = cnt_w(LOCK_STABLE);
    localparam int unsigned TO_W = cnt_w(LOCK_TIMEOUT);
    localparam int unsigned RT_W = cnt_w(MAX_RETRY);
    localparam int unsigned VS_W = cnt_w(VS_SETTLE);

    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);
    localparam logic [SB_W-1:0] SB_LAST = SB_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(MAX_RETRY - 1);
    localparam logic [VS_W-1:0] VS_LAST = VS_W'(VS_SETTLE - 1);

    // Reset asserts asynchronously and is released on a clock edge.
    logic [1:0] rst_sr;
    logic       rst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rst_sr <= '1;
        else
            rst_sr <= {rst_sr[0], 1'b0};
    end

    assign rst = rst_sr[1];

    logic sreq, slock, svs, svs_d, svs_rise;

    hdmi_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_sel  (.clk(clk), .rst(rst), .d(sel_req),    .q(sreq));
    hdmi_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (.clk(clk), .rst(rst), .d(pll_locked), .q(slock));
    hdmi_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_vs   (.clk(clk), .rst(rst), .d(vs_in),      .q(svs));

    assign svs_rise = svs & ~svs_d;

    ctrl_state_t     state, state_n;
    logic            sel_n, pll_rst_n, mute_n, busy_n, fail_n;
    logic [RC_W-1:0] rst_cnt, rst_cnt_n;
    logic [SB_W-1:0] stab, stab_n;
    logic [TO_W-1:0] tmo, tmo_n;
    logic [RT_W-1:0] retry, retry_n;
    logic [VS_W-1:0] vs_cnt, vs_cnt_n;
    logic            sel_chg;

    assign sel_chg = (sreq != sel_out);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_MUTE;
            sel_out <= 1'b0;
            pll_rst <= 1'b1;
            mute    <= 1'b1;
            busy    <= 1'b1;
            fail    <= 1'b0;
            rst_cnt <= '0;
            stab    <= '0;
            tmo     <= '0;
            retry   <= '0;
            vs_cnt  <= '0;
            svs_d   <= 1'b0;
        end else begin
            state   <= state_n;
            sel_out <= sel_n;
            pll_rst <= pll_rst_n;
            mute    <= mute_n;
            busy    <= busy_n;
            fail    <= fail_n;
            rst_cnt <= rst_cnt_n;
            stab    <= stab_n;
            tmo     <= tmo_n;
            retry   <= retry_n;
            vs_cnt  <= vs_cnt_n;
            svs_d   <= svs;
        end
    end

    // Outputs are computed one state ahead so they change on the same edge as the state.
    always_comb begin
        state_n   = state;
        sel_n     = sel_out;
        pll_rst_n = pll_rst;
        mute_n    = mute;
        busy_n    = busy;
        fail_n    = fail;
        rst_cnt_n = rst_cnt;
        stab_n    = stab;
        tmo_n     = tmo;
        retry_n   = retry;
        vs_cnt_n  = vs_cnt;

        unique case (state)
            ST_MUTE: begin
                state_n   = ST_PLL_RST;
                sel_n     = sreq;
                pll_rst_n = 1'b1;
                retry_n   = '0;
                rst_cnt_n = '0;
            end
            ST_PLL_RST: begin
                if (sel_chg) begin
                    state_n = ST_MUTE;
                end else if (rst_cnt == RC_LAST) begin
                    state_n   = ST_WAIT_LOCK;
                    pll_rst_n = 1'b0;
                    stab_n    = '0;
                    tmo_n     = '0;
                end else begin
                    rst_cnt_n = rst_cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (sel_chg) begin
                    state_n = ST_MUTE;
                end else if (tmo == TO_LAST) begin
                    if (retry == RT_LAST) begin
                        state_n = ST_FAIL;
                        fail_n  = 1'b1;
                    end else begin
                        state_n   = ST_PLL_RST;
                        retry_n   = retry + 1'b1;
                        pll_rst_n = 1'b1;
                        rst_cnt_n = '0;
                    end
                end else if (slock && stab == SB_LAST) begin
                    state_n  = ST_WAIT_VS;
                    vs_cnt_n = '0;
                end else begin
                    tmo_n  = tmo + 1'b1;
                    stab_n = slock ? stab + 1'b1 : '0;
                end
            end
            ST_WAIT_VS: begin
                if (sel_chg || !slock) begin
                    state_n = ST_MUTE;
                end else if (svs_rise) begin
                    if (vs_cnt == VS_LAST) begin
                        state_n = ST_RUN;
                        mute_n  = 1'b0;
                        busy_n  = 1'b0;
                    end else begin
                        vs_cnt_n = vs_cnt + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (sel_chg || !slock)
                    state_n = ST_MUTE;
            end
            ST_FAIL: begin
                pll_rst_n = 1'b0;
                if (sel_chg)
                    state_n = ST_MUTE;
            end
            default: state_n = ST_MUTE;
        endcase

        if (state_n == ST_MUTE) begin
            mute_n = 1'b1;
            busy_n = 1'b1;
            fail_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_hdmi_src_switch_ctrl.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle,
// the monitor pops and compares whenever the output vector changes.
module tb_hdmi_src_switch_ctrl;

    localparam int unsigned TB_SYNC   = 2;
    localparam int unsigned TB_RST    = 4;
    localparam int unsigned TB_STAB   = 8;
    localparam int unsigned TB_TMO    = 64;
    localparam int unsigned TB_RETRY  = 3;
    localparam int unsigned TB_VS     = 2;

    // Output vector order: {sel_out, pll_rst, mute, busy, fail}
    localparam logic [4:0] V_RESET = 5'b01110;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel_req = 1'b0;
    logic pll_locked = 1'b0;
    logic vs_in = 1'b0;
    logic sel_out, pll_rst, mute, busy, fail;
    logic [4:0] ov;

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  vec;
        int unsigned at;
    } exp_t;

    exp_t exp_q[$];

    hdmi_src_switch_ctrl #(
        .SYNC_STAGES (TB_SYNC),
        .RST_CYC     (TB_RST),
        .LOCK_STABLE (TB_STAB),
        .LOCK_TIMEOUT(TB_TMO),
        .MAX_RETRY   (TB_RETRY),
        .VS_SETTLE   (TB_VS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sel_req   (sel_req),
        .pll_locked(pll_locked),
        .vs_in     (vs_in),
        .sel_out   (sel_out),
        .pll_rst   (pll_rst),
        .mute      (mute),
        .busy      (busy),
        .fail      (fail)
    );

    assign ov = {sel_out, pll_rst, mute, busy, fail};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_ev(input logic [4:0] v, input int unsigned at);
        exp_t e;
        e.vec = v;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    task automatic vs_pulse(input int unsigned c);
        wait_cyc(c);
        vs_in = 1'b1;
        wait_cyc(c + 2);
        vs_in = 1'b0;
    endtask

    task automatic check_now(input string name, input logic [4:0] req);
        n_checks++;
        if (ov !== req) begin
            n_fail++;
            $display("FAIL %s: cycle %0d outputs %b, required %b", name, cyc, ov, req);
        end
    endtask

    initial begin : monitor
        logic [4:0] prev;
        exp_t e;
        prev = V_RESET;
        forever begin
            @(negedge clk);
            if (ov !== prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: cycle %0d outputs %b, no change expected", cyc, ov);
                end else begin
                    e = exp_q.pop_front();
                    if (ov !== e.vec || cyc != e.at) begin
                        n_fail++;
                        $display("FAIL output_event: cycle %0d outputs %b, required cycle %0d outputs %b",
                                 cyc, ov, e.at, e.vec);
                    end
                end
                prev = ov;
            end
        end
    end

    initial begin : stim
        // 1: reset release at cycle 3, lock 10 cycles after pll_rst falls, two vs pulses
        expect_ev(5'b00110, 10);
        expect_ev(5'b00000, 42);
        wait_cyc(3);
        check_now("reset_state", V_RESET);
        reset = 1'b0;
        wait_cyc(20);
        pll_locked = 1'b1;
        vs_pulse(33);
        vs_pulse(39);

        // 2: switch to FT812 from RUN; PLL drops lock while reset
        expect_ev(5'b00110, 53);
        expect_ev(5'b11110, 54);
        expect_ev(5'b10110, 58);
        expect_ev(5'b10000, 89);
        wait_cyc(50);
        sel_req    = 1'b1;
        pll_locked = 1'b0;
        wait_cyc(68);
        pll_locked = 1'b1;
        vs_pulse(80);
        vs_pulse(86);

        // 3: lock never returns: three attempts 64 cycles apart, then FAIL; toggle clears
        expect_ev(5'b10110, 103);
        expect_ev(5'b01110, 104);
        expect_ev(5'b00110, 108);
        expect_ev(5'b01110, 172);
        expect_ev(5'b00110, 176);
        expect_ev(5'b01110, 240);
        expect_ev(5'b00110, 244);
        expect_ev(5'b00111, 308);
        expect_ev(5'b00110, 323);
        expect_ev(5'b11110, 324);
        expect_ev(5'b10110, 328);
        wait_cyc(100);
        sel_req    = 1'b0;
        pll_locked = 1'b0;
        wait_cyc(315);
        check_now("fail_hold", 5'b00111);
        wait_cyc(320);
        sel_req = 1'b1;

        // 4: lock glitch at stab=5; early vs pulse must be ignored
        expect_ev(5'b10000, 369);
        wait_cyc(340);
        pll_locked = 1'b1;
        wait_cyc(345);
        pll_locked = 1'b0;
        wait_cyc(346);
        pll_locked = 1'b1;
        vs_pulse(350);
        vs_pulse(360);
        vs_pulse(366);

        // 5: one-cycle lock loss in RUN forces a full resequence
        expect_ev(5'b10110, 383);
        expect_ev(5'b11110, 384);
        expect_ev(5'b10110, 388);
        expect_ev(5'b10000, 409);
        wait_cyc(380);
        pll_locked = 1'b0;
        wait_cyc(381);
        pll_locked = 1'b1;
        vs_pulse(400);
        vs_pulse(406);

        // 6: sel change in WAIT_VS restarts; reset pulsed during WAIT_LOCK
        expect_ev(5'b10110, 423);
        expect_ev(5'b11110, 424);
        expect_ev(5'b10110, 428);
        expect_ev(5'b01110, 442);
        expect_ev(5'b00110, 446);
        expect_ev(5'b01110, 449);
        expect_ev(5'b00110, 458);
        expect_ev(5'b00000, 478);
        wait_cyc(420);
        pll_locked = 1'b0;
        wait_cyc(421);
        pll_locked = 1'b1;
        wait_cyc(438);
        sel_req = 1'b0;
        wait_cyc(448);
        #2 reset = 1'b1;
        #1 check_now("async_reset", V_RESET);
        wait_cyc(451);
        reset = 1'b0;
        vs_pulse(469);
        vs_pulse(475);

        wait_cyc(500);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected events outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
